// File: rtl/q_measure_pkg.sv
// Shared control definitions for the current-measurement front-end and the
// bisection controller that consumes its result.
package q_measure_pkg;

  // Result/sample width shared with the bisection controller.
  localparam int Q_WIDTH = 10;

  typedef enum logic [1:0] {
    Q_IDLE   = 2'd0,
    Q_SETTLE = 2'd1,
    Q_ACCUM  = 2'd2,
    Q_DONE   = 2'd3
  } q_state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable up/down counter with a terminal-count flag. Used to time the
// settling interval after a reference change; reusable by other stages.
module settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  input  logic             up,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Counter register: load wins over counting.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every register so all flops update
    // together at the edge, independent of statement order.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/q_measure.sv
// Measurement front-end: waits a settling interval after each reference
// update, averages 2^LOG2_N ADC samples and presents the floored mean.
module q_measure
  import q_measure_pkg::*;
#(
  parameter int WIDTH         = Q_WIDTH,
  parameter int LOG2_N        = 4,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] measured_q,
  output logic             ready,
  output logic             busy,
  output logic             overrange
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = WIDTH + LOG2_N;   // N full-scale samples fit exactly
  localparam int CNT_W = LOG2_N + 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST =
    SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  // With no settling interval a start goes straight to accumulation.
  localparam q_state_t FIRST_STATE = (SETTLE_CYCLES > 0) ? Q_SETTLE : Q_ACCUM;

  q_state_t         state, next_state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             settle_done;
  logic             accept;
  logic             last;

  settle_timer #(
    .CNT_W (SET_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (start),
    .load_value ('0),
    .en         (state == Q_SETTLE),
    .up         (1'b1),
    .terminal   (SETTLE_LAST),
    .done       (settle_done)
  );

  assign acc_sum = acc + ACC_W'(sample);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= Q_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; start restarts from any state.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    if (start) begin
      next_state = FIRST_STATE;
    end else begin
      case (state)
        Q_SETTLE: if (settle_done) next_state = Q_ACCUM;
        Q_ACCUM:  if (last)        next_state = Q_DONE;
        default:  next_state = state;
      endcase
    end
  end

  // Datapath strobes; a sample coinciding with start is never accepted.
  always_comb begin
    accept = 1'b0;
    last   = 1'b0;
    if (state == Q_ACCUM) begin
      accept = sample_valid && !start;
      last   = accept && (cnt == CNT_LAST);
    end
  end

  // Accumulator, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      measured_q <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      overrange  <= 1'b0;
    end else begin
      ready <= (next_state == Q_DONE);
      busy  <= (next_state == Q_SETTLE) || (next_state == Q_ACCUM);
      if (start) begin
        acc       <= '0;
        cnt       <= '0;
        overrange <= 1'b0;
      end else if (accept) begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
        if (sample == ALL_ONES) overrange <= 1'b1;
        if (last) measured_q <= WIDTH'(acc_sum >> LOG2_N);
      end
    end
  end

endmodule

// File: tb/tb_q_measure.sv
// Self-checking bench for q_measure: a transaction-level model (start time,
// accepted-sample sum and count) is compared every cycle against two DUT
// configurations, with hand-computed expectations at key cycles.
module tb_q_measure;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=10, LOG2_N=2, SETTLE_CYCLES=4
  logic       a_rst, a_start, a_sv;
  logic [9:0] a_sample, a_q;
  logic       a_ready, a_busy, a_over;
  // Instance B: WIDTH=10, LOG2_N=0, SETTLE_CYCLES=0
  logic       b_rst, b_start, b_sv;
  logic [9:0] b_sample, b_q;
  logic       b_ready, b_busy, b_over;

  q_measure #(.WIDTH(10), .LOG2_N(2), .SETTLE_CYCLES(4)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .sample_valid(a_sv),
    .sample(a_sample), .measured_q(a_q), .ready(a_ready), .busy(a_busy),
    .overrange(a_over)
  );

  q_measure #(.WIDTH(10), .LOG2_N(0), .SETTLE_CYCLES(0)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .sample_valid(b_sv),
    .sample(b_sample), .measured_q(b_q), .ready(b_ready), .busy(b_busy),
    .overrange(b_over)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit active;
    int start_edge;
    int sum;
    int cnt;
    int q;
    bit ready;
    bit over;
  } model_t;

  model_t m[2];
  int     edge_no = 0;

  task automatic model_step(input int k, input logic r, input logic st,
                            input logic sv, input int smp, input int settle,
                            input int n);
    if (r) begin
      m[k].active = 0; m[k].start_edge = 0; m[k].sum = 0; m[k].cnt = 0;
      m[k].q = 0; m[k].ready = 0; m[k].over = 0;
    end else if (st) begin
      m[k].active = 1; m[k].start_edge = edge_no; m[k].sum = 0;
      m[k].cnt = 0; m[k].over = 0; m[k].ready = 0;
    end else if (m[k].active && edge_no > m[k].start_edge + settle && sv) begin
      m[k].sum += smp;
      m[k].cnt++;
      if (smp == 1023) m[k].over = 1;
      if (m[k].cnt == n) begin
        m[k].q      = m[k].sum / n;
        m[k].ready  = 1;
        m[k].active = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, a_rst, a_start, a_sv, int'(a_sample), 4, 4);
    model_step(1, b_rst, b_start, b_sv, int'(b_sample), 0, 1);
    edge_no++;
  end

  // Per-cycle comparison, sampled after the edge has settled.
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      check("a_q",     a_q,     m[0].q);
      check("a_ready", a_ready, m[0].ready);
      check("a_busy",  a_busy,  m[0].active);
      check("a_over",  a_over,  m[0].over);
      check("b_q",     b_q,     m[1].q);
      check("b_ready", b_ready, m[1].ready);
      check("b_busy",  b_busy,  m[1].active);
      check("b_over",  b_over,  m[1].over);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_a(input logic r, input logic st, input logic sv,
                         input logic [9:0] smp);
    @(negedge clk);
    a_rst = r; a_start = st; a_sv = sv; a_sample = smp;
  endtask

  task automatic drive_b(input logic r, input logic st, input logic sv,
                         input logic [9:0] smp);
    @(negedge clk);
    b_rst = r; b_start = st; b_sv = sv; b_sample = smp;
  endtask

  task automatic look();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [9:0] seq [4];
    a_rst = 1; a_start = 0; a_sv = 0; a_sample = 0;
    b_rst = 1; b_start = 0; b_sv = 0; b_sample = 0;
    repeat (2) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    check("rst_a_q", a_q, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_b_over", b_over, 0);
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);

    // Test 1: 100,200,300,400 -> 250 at cycle 9; settle-time samples ignored.
    drive_a(0, 1, 0, 0);
    repeat (4) drive_a(0, 0, 1, 10'd999);
    seq = '{10'd100, 10'd200, 10'd300, 10'd400};
    for (int i = 0; i < 4; i++) begin
      drive_a(0, 0, 1, seq[i]);
      if (i == 3) begin
        check("t1_busy_c8", a_busy, 1);
        check("t1_ready_c8", a_ready, 0);
      end
    end
    look();
    check("t1_ready", a_ready, 1);
    check("t1_q", a_q, 250);
    check("t1_busy", a_busy, 0);
    check("t1_model_q", m[0].q, 250);
    drive_a(0, 0, 0, 0);

    // Test 2a: 1,1,1,2 -> floor(5/4) = 1.
    drive_a(0, 1, 0, 0);
    repeat (4) drive_a(0, 0, 0, 0);
    seq = '{10'd1, 10'd1, 10'd1, 10'd2};
    for (int i = 0; i < 4; i++) drive_a(0, 0, 1, seq[i]);
    look();
    check("t2_q_trunc", a_q, 1);
    check("t2_model_q", m[0].q, 1);
    drive_a(0, 0, 0, 0);

    // Test 2b: valid toggling 1/0, three stalls -> ready at start+12.
    drive_a(0, 1, 0, 0);
    repeat (4) drive_a(0, 0, 0, 0);
    seq = '{10'd5, 10'd6, 10'd7, 10'd8};
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) drive_a(0, 0, 1, seq[i/2]);
      else            drive_a(0, 0, 0, 10'd777);
      if (i == 6) begin
        check("t2_ready_c11", a_ready, 0);
        check("t2_q_held", a_q, 1);
      end
    end
    look();
    check("t2_ready_c12", a_ready, 1);
    check("t2_q_stall", a_q, 6);
    drive_a(0, 0, 0, 0);

    // Test 3: abort in ACCUM after two samples, restart with 10..40 -> 25.
    drive_a(0, 1, 0, 0);
    repeat (4) drive_a(0, 0, 0, 0);
    drive_a(0, 0, 1, 10'd50);
    drive_a(0, 0, 1, 10'd60);
    drive_a(0, 1, 1, 10'd1023);   // sample with start must be dropped
    repeat (4) drive_a(0, 0, 0, 0);
    seq = '{10'd10, 10'd20, 10'd30, 10'd40};
    for (int i = 0; i < 4; i++) begin
      drive_a(0, 0, 1, seq[i]);
      if (i == 3) begin
        check("t3_q_held", a_q, 6);
        check("t3_busy", a_busy, 1);
      end
    end
    look();
    check("t3_ready", a_ready, 1);
    check("t3_q", a_q, 25);
    check("t3_over", a_over, 0);
    drive_a(0, 0, 0, 0);

    // Test 4: reset in SETTLE, then in DONE, then rst together with start.
    drive_a(0, 1, 0, 0);
    drive_a(0, 0, 0, 0);
    drive_a(1, 0, 0, 0);
    look();
    check("t4_settle_rst_busy", a_busy, 0);
    check("t4_settle_rst_q", a_q, 0);
    drive_a(0, 1, 0, 0);
    repeat (4) drive_a(0, 0, 0, 0);
    repeat (4) drive_a(0, 0, 1, 10'd8);
    look();
    check("t4_q8", a_q, 8);
    drive_a(1, 0, 0, 0);
    look();
    check("t4_done_rst_q", a_q, 0);
    check("t4_done_rst_ready", a_ready, 0);
    drive_a(1, 1, 0, 0);
    look();
    check("t4_rst_start_busy", a_busy, 0);
    drive_a(0, 0, 0, 0);
    look();
    check("t4_idle_busy", a_busy, 0);

    // Test B: no settle, N=1, full-scale sample.
    drive_b(0, 1, 0, 0);
    look();
    check("tb_busy_c1", b_busy, 1);
    check("tb_ready_c1", b_ready, 0);
    drive_b(0, 0, 1, 10'd1023);
    look();
    check("tb_q", b_q, 1023);
    check("tb_over", b_over, 1);
    check("tb_ready_c2", b_ready, 1);
    check("tb_model_q", m[1].q, 1023);
    drive_b(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
